// File: rtl/issue_pair_unit.sv
// Dual-issue pairing stage and ID-stage latch: pairs or splits a decoded
// instruction pair, holds a split slot 1 for one cycle, honours stall/flush.
//
// state | meaning
// ------+------------------------------------------------------------------
// PAIR  | accepting decode pairs; hold buffer empty
// HOLD  | split slot 1 waiting in hold buffer; issues next as ID slot 0
module issue_pair_unit #(
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid_0,
    input  logic                 in_valid_1,
    output logic                 in_ready,

    input  logic [3:0]           in_rs1_0,
    input  logic [3:0]           in_rs2_0,
    input  logic [3:0]           in_rd_0,
    input  logic                 in_rd_we_0,
    input  logic                 in_mem_read_0,
    input  logic                 in_mem_write_0,
    input  logic                 in_branch_0,
    input  logic [PAYLOAD_W-1:0] in_payload_0,

    input  logic [3:0]           in_rs1_1,
    input  logic [3:0]           in_rs2_1,
    input  logic [3:0]           in_rd_1,
    input  logic                 in_rd_we_1,
    input  logic                 in_mem_read_1,
    input  logic                 in_mem_write_1,
    input  logic                 in_branch_1,
    input  logic [PAYLOAD_W-1:0] in_payload_1,

    input  logic                 stall,
    input  logic                 flush,

    output logic                 id_valid_0,
    output logic                 id_valid_1,
    output logic [3:0]           id_rs1_addr_0,
    output logic [3:0]           id_rs2_addr_0,
    output logic [3:0]           id_rd_addr_0,
    output logic [3:0]           id_rs1_addr_1,
    output logic [3:0]           id_rs2_addr_1,
    output logic [3:0]           id_rd_addr_1,
    output logic                 id_rd_we_0,
    output logic                 id_rd_we_1,
    output logic                 id_mem_read_0,
    output logic                 id_mem_read_1,
    output logic                 id_mem_write_0,
    output logic                 id_mem_write_1,
    output logic                 id_branch_0,
    output logic                 id_branch_1,
    output logic [PAYLOAD_W-1:0] id_payload_0,
    output logic [PAYLOAD_W-1:0] id_payload_1,

    output logic [CNT_W-1:0]     split_count
);

    typedef struct packed {
        logic [3:0]           rs1;
        logic [3:0]           rs2;
        logic [3:0]           rd;
        logic                 rd_we;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    typedef enum logic {
        PAIR = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    slot_t            id0_q, id0_d;
    slot_t            id1_q, id1_d;
    slot_t            hold_q, hold_d;
    logic             id_valid_0_q, id_valid_0_d;
    logic             id_valid_1_q, id_valid_1_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    slot_t in0, in1;
    logic  raw_hzd, waw_hzd, mem_conflict, can_pair;

    assign in0 = '{rs1: in_rs1_0, rs2: in_rs2_0, rd: in_rd_0, rd_we: in_rd_we_0,
                   mem_read: in_mem_read_0, mem_write: in_mem_write_0,
                   branch: in_branch_0, payload: in_payload_0};
    assign in1 = '{rs1: in_rs1_1, rs2: in_rs2_1, rd: in_rd_1, rd_we: in_rd_we_1,
                   mem_read: in_mem_read_1, mem_write: in_mem_write_1,
                   branch: in_branch_1, payload: in_payload_1};

    // r0 is exempt from RAW (never really written) but not from WAW
    assign raw_hzd      = in_rd_we_0 && (in_rd_0 != 4'd0) &&
                          ((in_rd_0 == in_rs1_1) || (in_rd_0 == in_rs2_1));
    assign waw_hzd      = in_rd_we_0 && in_rd_we_1 && (in_rd_0 == in_rd_1);
    assign mem_conflict = (in_mem_read_0 || in_mem_write_0) &&
                          (in_mem_read_1 || in_mem_write_1);
    assign can_pair     = in_valid_1 && !raw_hzd && !waw_hzd && !mem_conflict && !in_branch_0;

    assign in_ready = (state_q == PAIR) && !stall && !flush;

    always_comb begin
        state_d      = state_q;
        id0_d        = id0_q;
        id1_d        = id1_q;
        hold_d       = hold_q;
        id_valid_0_d = id_valid_0_q;
        id_valid_1_d = id_valid_1_q;
        split_cnt_d  = split_cnt_q;

        if (flush) begin
            id_valid_0_d = 1'b0;
            id_valid_1_d = 1'b0;
            state_d      = PAIR;
        end else if (!stall) begin
            if (state_q == HOLD) begin
                id0_d        = hold_q;
                id_valid_0_d = 1'b1;
                id_valid_1_d = 1'b0;
                state_d      = PAIR;
            end else if (in_valid_0) begin
                id0_d        = in0;
                id_valid_0_d = 1'b1;
                id_valid_1_d = 1'b0;
                if (can_pair) begin
                    id1_d        = in1;
                    id_valid_1_d = 1'b1;
                end else if (in_valid_1) begin
                    hold_d      = in1;
                    state_d     = HOLD;
                    split_cnt_d = split_cnt_q + CNT_W'(1);
                end
            end else if (in_valid_1) begin
                id0_d        = in1;
                id_valid_0_d = 1'b1;
                id_valid_1_d = 1'b0;
            end else begin
                id_valid_0_d = 1'b0;
                id_valid_1_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PAIR;
            id0_q        <= '0;
            id1_q        <= '0;
            hold_q       <= '0;
            id_valid_0_q <= 1'b0;
            id_valid_1_q <= 1'b0;
            split_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            id0_q        <= id0_d;
            id1_q        <= id1_d;
            hold_q       <= hold_d;
            id_valid_0_q <= id_valid_0_d;
            id_valid_1_q <= id_valid_1_d;
            split_cnt_q  <= split_cnt_d;
        end
    end

    assign id_valid_0     = id_valid_0_q;
    assign id_valid_1     = id_valid_1_q;
    assign id_rs1_addr_0  = id0_q.rs1;
    assign id_rs2_addr_0  = id0_q.rs2;
    assign id_rd_addr_0   = id0_q.rd;
    assign id_rd_we_0     = id0_q.rd_we;
    assign id_mem_read_0  = id0_q.mem_read;
    assign id_mem_write_0 = id0_q.mem_write;
    assign id_branch_0    = id0_q.branch;
    assign id_payload_0   = id0_q.payload;
    assign id_rs1_addr_1  = id1_q.rs1;
    assign id_rs2_addr_1  = id1_q.rs2;
    assign id_rd_addr_1   = id1_q.rd;
    assign id_rd_we_1     = id1_q.rd_we;
    assign id_mem_read_1  = id1_q.mem_read;
    assign id_mem_write_1 = id1_q.mem_write;
    assign id_branch_1    = id1_q.branch;
    assign id_payload_1   = id1_q.payload;
    assign split_count    = split_cnt_q;

endmodule

// File: tb/tb_issue_pair_unit.sv
// Randomized + directed bench for issue_pair_unit against a queue-based
// model of the issue rules.
module tb_issue_pair_unit;

    typedef struct packed {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        we;
        logic        mr;
        logic        mw;
        logic        br;
        logic [63:0] pl;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid_0 = 0, in_valid_1 = 0, stall = 0, flush = 0;
    ins_t a = '0, b = '0;
    logic in_ready;
    logic id_valid_0, id_valid_1;
    logic [3:0] id_rs1_addr_0, id_rs2_addr_0, id_rd_addr_0;
    logic [3:0] id_rs1_addr_1, id_rs2_addr_1, id_rd_addr_1;
    logic id_rd_we_0, id_rd_we_1, id_mem_read_0, id_mem_read_1;
    logic id_mem_write_0, id_mem_write_1, id_branch_0, id_branch_1;
    logic [63:0] id_payload_0, id_payload_1;
    logic [15:0] split_count;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic   m_v0 = 0, m_v1 = 0;
    ins_t   m_s0 = '0, m_s1 = '0;
    ins_t   held[$];
    int     m_cnt = 0;

    always #5 clk = ~clk;

    issue_pair_unit #(.PAYLOAD_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1), .in_ready(in_ready),
        .in_rs1_0(a.rs1), .in_rs2_0(a.rs2), .in_rd_0(a.rd), .in_rd_we_0(a.we),
        .in_mem_read_0(a.mr), .in_mem_write_0(a.mw), .in_branch_0(a.br), .in_payload_0(a.pl),
        .in_rs1_1(b.rs1), .in_rs2_1(b.rs2), .in_rd_1(b.rd), .in_rd_we_1(b.we),
        .in_mem_read_1(b.mr), .in_mem_write_1(b.mw), .in_branch_1(b.br), .in_payload_1(b.pl),
        .stall(stall), .flush(flush),
        .id_valid_0(id_valid_0), .id_valid_1(id_valid_1),
        .id_rs1_addr_0(id_rs1_addr_0), .id_rs2_addr_0(id_rs2_addr_0), .id_rd_addr_0(id_rd_addr_0),
        .id_rs1_addr_1(id_rs1_addr_1), .id_rs2_addr_1(id_rs2_addr_1), .id_rd_addr_1(id_rd_addr_1),
        .id_rd_we_0(id_rd_we_0), .id_rd_we_1(id_rd_we_1),
        .id_mem_read_0(id_mem_read_0), .id_mem_read_1(id_mem_read_1),
        .id_mem_write_0(id_mem_write_0), .id_mem_write_1(id_mem_write_1),
        .id_branch_0(id_branch_0), .id_branch_1(id_branch_1),
        .id_payload_0(id_payload_0), .id_payload_1(id_payload_1),
        .split_count(split_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t mk(input int rs1, rs2, rd, input logic we, mr, mw, br);
        ins_t x;
        x.rs1 = 4'(rs1); x.rs2 = 4'(rs2); x.rd = 4'(rd);
        x.we = we; x.mr = mr; x.mw = mw; x.br = br;
        x.pl = {$urandom, $urandom};
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        x.rs1 = 4'($urandom_range(0, 7));
        x.rs2 = 4'($urandom_range(0, 7));
        x.rd  = 4'($urandom_range(0, 7));
        x.we  = ($urandom % 4) != 0;
        x.mr  = ($urandom % 4) == 0;
        x.mw  = ($urandom % 5) == 0;
        x.br  = ($urandom % 6) == 0;
        x.pl  = {$urandom, $urandom};
        return x;
    endfunction

    // two instructions may go together unless the younger one depends on or
    // collides with the older one, or they compete for the single memory port
    function automatic bit pairable(input ins_t o, input ins_t y);
        bit reads_old = o.we && o.rd != 0 && (o.rd == y.rs1 || o.rd == y.rs2);
        bit same_dest = o.we && y.we && o.rd == y.rd;
        bit both_mem  = (o.mr || o.mw) && (y.mr || y.mw);
        return !(reads_old || same_dest || both_mem || o.br);
    endfunction

    function automatic ins_t dut_slot0();
        return {id_rs1_addr_0, id_rs2_addr_0, id_rd_addr_0, id_rd_we_0,
                id_mem_read_0, id_mem_write_0, id_branch_0, id_payload_0};
    endfunction

    function automatic ins_t dut_slot1();
        return {id_rs1_addr_1, id_rs2_addr_1, id_rd_addr_1, id_rd_we_1,
                id_mem_read_1, id_mem_write_1, id_branch_1, id_payload_1};
    endfunction

    task automatic model_reset();
        m_v0 = 0; m_v1 = 0; m_s0 = '0; m_s1 = '0; m_cnt = 0;
        held.delete();
    endtask

    task automatic compare_all();
        chk("valid0", id_valid_0, m_v0);
        chk("valid1", id_valid_1, m_v1);
        if (m_v0) chk("slot0", dut_slot0(), m_s0);
        if (m_v1) chk("slot1", dut_slot1(), m_s1);
        chk("split_count", split_count, 16'(m_cnt));
    endtask

    task automatic step(input logic v0, input logic v1, input ins_t x0, input ins_t x1,
                        input logic st, input logic fl);
        @(negedge clk);
        in_valid_0 = v0; in_valid_1 = v1; a = x0; b = x1; stall = st; flush = fl;
        #1;
        chk("in_ready", in_ready, held.size() == 0 && !st && !fl);
        if (fl) begin
            m_v0 = 0; m_v1 = 0;
            held.delete();
        end else if (!st) begin
            if (held.size() > 0) begin
                m_s0 = held.pop_front(); m_v0 = 1; m_v1 = 0;
            end else if (v0) begin
                m_s0 = x0; m_v0 = 1; m_v1 = 0;
                if (v1 && pairable(x0, x1)) begin
                    m_s1 = x1; m_v1 = 1;
                end else if (v1) begin
                    held.push_back(x1);
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end else if (v1) begin
                m_s0 = x1; m_v0 = 1; m_v1 = 0;
            end else begin
                m_v0 = 0; m_v1 = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        ins_t p, q;
        model_reset();
        #12;
        chk("rst_valid0", id_valid_0, 1'b0);
        chk("rst_valid1", id_valid_1, 1'b0);
        chk("rst_slot0", dut_slot0(), '0);
        chk("rst_count", split_count, 16'd0);
        @(negedge clk);
        rst = 0;

        // independent ADDs pair
        step(1, 1, mk(2, 3, 1, 1, 0, 0, 0), mk(5, 6, 4, 1, 0, 0, 0), 0, 0);
        chk("pair_rd1", id_rd_addr_1, 4'd4);
        chk("pair_v1", id_valid_1, 1'b1);

        // RAW split: held instruction issues next cycle as slot 0
        step(1, 1, mk(2, 0, 1, 1, 0, 0, 0), mk(1, 6, 5, 1, 0, 0, 0), 0, 0);
        chk("raw_rd0", id_rd_addr_0, 4'd1);
        chk("raw_ready", in_ready, 1'b0);
        step(1, 1, rnd_ins(), rnd_ins(), 0, 0);
        chk("raw_rs1", id_rs1_addr_0, 4'd1);
        chk("raw_cnt", split_count, 16'd1);

        // r0 exempt from RAW; WAW on r7 splits
        step(1, 1, mk(2, 3, 0, 1, 0, 0, 0), mk(0, 0, 4, 1, 0, 0, 0), 0, 0);
        chk("r0_pair", id_valid_1, 1'b1);
        step(1, 1, mk(2, 3, 7, 1, 0, 0, 0), mk(4, 5, 7, 1, 0, 0, 0), 0, 0);
        idle();

        // load+store split, branch+ADD split
        step(1, 1, mk(2, 0, 1, 1, 1, 0, 0), mk(3, 4, 0, 0, 0, 1, 0), 0, 0);
        idle();
        step(1, 1, mk(2, 3, 0, 0, 0, 0, 1), mk(5, 6, 8, 1, 0, 0, 0), 0, 0);
        idle();
        chk("mem_br_cnt", split_count, 16'd4);

        // stall for 3 cycles during HOLD
        step(1, 1, mk(2, 3, 9, 1, 0, 0, 0), mk(9, 1, 10, 1, 0, 0, 0), 0, 0);
        repeat (3) step(1, 1, rnd_ins(), rnd_ins(), 1, 0);
        step(1, 1, rnd_ins(), rnd_ins(), 0, 0);
        chk("stall_issue_rd", id_rd_addr_0, 4'd10);

        // flush + stall together during HOLD
        step(1, 1, mk(2, 3, 11, 1, 0, 0, 0), mk(11, 1, 12, 1, 0, 0, 0), 0, 0);
        step(1, 1, rnd_ins(), rnd_ins(), 1, 1);
        chk("flush_v0", id_valid_0, 1'b0);
        idle();
        chk("flush_noheld", id_valid_0, 1'b0);

        // asynchronous reset mid-HOLD
        p = mk(2, 3, 13, 1, 0, 0, 0);
        q = mk(13, 0, 14, 1, 0, 0, 0);
        step(1, 1, p, q, 0, 0);
        @(negedge clk);
        in_valid_0 = 0; in_valid_1 = 0; stall = 0; flush = 0;
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_v0", id_valid_0, 1'b0);
        chk("arst_cnt", split_count, 16'd0);
        chk("arst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 0;
        idle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom % 4 != 0, $urandom % 3 != 0, rnd_ins(), rnd_ins(),
                 $urandom % 5 == 0, $urandom % 12 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_pair_unit.md
Name: issue_pair_unit

Overview:
- Dual-issue pairing stage and ID-stage latch.
- Accepts a decoded instruction pair from decode and decides whether both instructions may issue together. If they cannot, it splits the pair, issuing slot 1 one cycle later as slot 0.
- Drives the registered ID-stage fields consumed by the hazard/forwarding logic and the ID/EX register.
- Honours the pipeline stall and branch flush.

Parameters:
- PAYLOAD_W, 64, width of the opaque per-instruction payload (opcode, immediate, PC), carried unmodified.
- CNT_W, 16, width of the split performance counter.

Ports:
- clk  in  1  clock (single clock domain)
- rst  in  1  asynchronous, active-high reset
- in_valid_0  in  1  decode slot 0 valid
- in_valid_1  in  1  decode slot 1 valid
- in_ready  out  1  pair accepted this cycle
- in_rs1_0, in_rs2_0, in_rd_0  in  4 each  slot 0 register addresses
- in_rd_we_0, in_mem_read_0, in_mem_write_0, in_branch_0  in  1 each  slot 0 control
- in_payload_0  in  PAYLOAD_W  slot 0 payload
- in_rs1_1, in_rs2_1, in_rd_1, in_rd_we_1, in_mem_read_1, in_mem_write_1, in_branch_1, in_payload_1  in  as slot 0  slot 1 fields
- stall  in  1  hold ID contents; from hazard unit
- flush  in  1  kill ID contents and held instruction; from branch resolution
- id_valid_0, id_valid_1  out  1 each  ID slot valid
- id_rs1_addr_0, id_rs2_addr_0, id_rd_addr_0, id_rs1_addr_1, id_rs2_addr_1, id_rd_addr_1  out  4 each  ID register addresses
- id_rd_we_0/1, id_mem_read_0/1, id_mem_write_0/1, id_branch_0/1  out  1 each  ID control
- id_payload_0/1  out  PAYLOAD_W  ID payload
- split_count  out  CNT_W  number of pairs split (wraps)

Behaviour:
- All id_* outputs are registered.
  - Reset: all valids 0, all fields 0, split_count 0, state PAIR, hold buffer invalid.
  - Reset mid-operation discards everything immediately; no partial issue follows.
- in_ready = (state==PAIR) && !stall && !flush. It is combinational from state and inputs.
- can_pair = in_valid_1 && no RAW && no WAW && no memory conflict && no branch conflict, where:
  - RAW: in_rd_we_0 && in_rd_0!=0 && (in_rd_0==in_rs1_1 || in_rd_0==in_rs2_1).
  - WAW: in_rd_we_0 && in_rd_we_1 && in_rd_0==in_rd_1 (r0 included).
  - Memory conflict: slot 0 and slot 1 both access memory (read or write); there is a single memory port.
  - Branch conflict: in_branch_0 set (a branch always issues alone in slot 0).
- Priority per cycle: flush > stall > issue.
- flush: both id valids ←0, hold buffer dropped, state←PAIR, no input accepted. Fields other than valids are don't-care.
- stall (no flush): all id_* and the hold buffer keep their values; state unchanged.
- State PAIR, !stall, !flush:
  - in_valid_0 && can_pair: both slots load; id_valid_0=id_valid_1=1.
  - in_valid_0 && in_valid_1 && !can_pair: slot 0 loads, id_valid_1←0, slot 1 is captured into the hold buffer, state←HOLD, split_count+1 (wraps at 2^CNT_W).
  - in_valid_0 only: slot 0 loads, id_valid_1←0.
  - in_valid_1 only: slot 1 fields load into ID slot 0 (promotion), id_valid_1←0.
  - Neither valid: both id valids ←0 (bubble).
- State HOLD, !stall, !flush: the hold buffer loads into ID slot 0, id_valid_1←0, state←PAIR. in_ready=0 during this cycle.
- Latency: input to id_* is 1 cycle for a paired or slot-0 instruction. A split slot 1 appears 2 cycles after acceptance, absent stalls.
- Program order is preserved: the held instruction always issues before any newer input.

Test Plan:
- Reset then pair ADD r1←r2,r3 / ADD r4←r5,r6 (no dependence) → next cycle id_valid_0=id_valid_1=1, id_rd_addr_1=4, split_count=0.
- Pair r1←r2 / r5←r1,r6 (RAW) → cycle+1: only slot 0 valid (rd=1), in_ready=0. Cycle+2: id_valid_0=1 with id_rs1_addr_0=1, id_valid_1=0. split_count=1.
- Pair with rd=0 in slot 0 read by slot 1 → paired (r0 exempt). Same with both writing r7 → split.
- Load r1 paired with store, and branch in slot 0 paired with ADD → each split; split_count increments by 2.
- Stall held 3 cycles during HOLD → id_* and the held instruction unchanged and in_ready=0 throughout. The held instruction issues the cycle after stall drops.
- Flush and stall asserted together during HOLD → next cycle both valids 0, state PAIR, in_ready=1 once both drop, and the held instruction never appears. Assert rst mid-HOLD → the same clean state is reached asynchronously.
